// File: rtl/riscv_pkg.sv
// RV64I decode package: opcode constants, instruction class and immediate
// format enums, and the decoded-field payload registered by idecode.
package riscv_pkg;

    localparam int unsigned OPC_W    = 7;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FUNCT7_W = 7;

    localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP32     = 7'b0111011;
    localparam logic [OPC_W-1:0] OPC_FENCE    = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        CLASS_LUI      = 4'd0,
        CLASS_AUIPC    = 4'd1,
        CLASS_JAL      = 4'd2,
        CLASS_JALR     = 4'd3,
        CLASS_BRANCH   = 4'd4,
        CLASS_LOAD     = 4'd5,
        CLASS_STORE    = 4'd6,
        CLASS_OP_IMM   = 4'd7,
        CLASS_OP_IMM32 = 4'd8,
        CLASS_OP       = 4'd9,
        CLASS_OP32     = 4'd10,
        CLASS_FENCE    = 4'd11,
        CLASS_SYSTEM   = 4'd12,
        CLASS_ILLEGAL  = 4'd13
    } id_class_t;

    // IMM_NONE covers R-type, FENCE and illegal encodings (immediate = 0)
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        id_class_t           cls;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [FUNCT3_W-1:0] funct3;
        logic [FUNCT7_W-1:0] funct7;
        logic                rd_we;
        logic                illegal;
    } id_dec_t;

endpackage

// File: rtl/idecode_imm.sv
// Combinational immediate generator: selects and sign-extends the immediate
// of the given format from instruction[31].
// Ports: instruction (32), fmt (imm_fmt_t) -> imm_c (XLEN).
module idecode_imm
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instruction,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm_c
);

    logic sgn;
    assign sgn = instruction[31];

    always_comb begin
        imm_c = '0;
        case (fmt)
            IMM_I: imm_c = {{(XLEN-12){sgn}}, instruction[31:20]};
            IMM_S: imm_c = {{(XLEN-12){sgn}}, instruction[31:25], instruction[11:7]};
            IMM_B: imm_c = {{(XLEN-13){sgn}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            IMM_U: imm_c = {{(XLEN-32){sgn}}, instruction[31:12], 12'b0};
            IMM_J: imm_c = {{(XLEN-21){sgn}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

endmodule

// File: rtl/idecode.sv
// RV64I instruction decode stage with a single registered output slot.
// Captures one instruction per instr_valid episode (armed flag blocks
// re-capture of a word fetch keeps presenting), holds on stall, drops on flush.
// Inputs : clk, reset (async, active-high), instr_valid, instruction,
//          pc_current, stall, flush.
// Outputs: id_valid, id_pc, id_instr, id_class, id_rd, id_rs1, id_rs2,
//          id_funct3, id_funct7, id_imm, id_rd_we, id_illegal.
// Build option IDECODE_STATS_EN adds stat_decoded / stat_illegal counters.
module idecode
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [31:0]         instruction,
    input  logic [XLEN-1:0]     pc_current,
    input  logic                stall,
    input  logic                flush,
    output logic                id_valid,
    output logic [XLEN-1:0]     id_pc,
    output logic [31:0]         id_instr,
    output id_class_t           id_class,
    output logic [REG_W-1:0]    id_rd,
    output logic [REG_W-1:0]    id_rs1,
    output logic [REG_W-1:0]    id_rs2,
    output logic [FUNCT3_W-1:0] id_funct3,
    output logic [FUNCT7_W-1:0] id_funct7,
    output logic [XLEN-1:0]     id_imm,
    output logic                id_rd_we,
    output logic                id_illegal
`ifdef IDECODE_STATS_EN
    ,
    output logic [63:0]         stat_decoded,
    output logic [63:0]         stat_illegal
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t state;
    logic   armed;

    logic [OPC_W-1:0]    opcode_c;
    logic [FUNCT3_W-1:0] funct3_c;
    logic [FUNCT7_W-1:0] funct7_c;
    logic [5:0]          shtype_c;
    id_class_t           cls_c;
    imm_fmt_t            fmt_c;
    logic                writes_c;
    logic                bad_c;
    logic [REG_W-1:0]    rd_c;
    id_dec_t             dec_c;
    logic [XLEN-1:0]     imm_c;
    logic                accept_c;

    assign opcode_c = instruction[6:0];
    assign funct3_c = instruction[14:12];
    assign funct7_c = instruction[31:25];
    assign shtype_c = instruction[31:26];

    // Class, immediate format, rd-write intent and legality from the opcode
    always_comb begin
        cls_c    = CLASS_ILLEGAL;
        fmt_c    = IMM_NONE;
        writes_c = 1'b0;
        bad_c    = 1'b0;
        case (opcode_c)
            OPC_LUI: begin
                cls_c = CLASS_LUI;   fmt_c = IMM_U; writes_c = 1'b1;
            end
            OPC_AUIPC: begin
                cls_c = CLASS_AUIPC; fmt_c = IMM_U; writes_c = 1'b1;
            end
            OPC_JAL: begin
                cls_c = CLASS_JAL;   fmt_c = IMM_J; writes_c = 1'b1;
            end
            OPC_JALR: begin
                cls_c = CLASS_JALR;  fmt_c = IMM_I; writes_c = 1'b1;
                bad_c = (funct3_c != 3'd0);
            end
            OPC_BRANCH: begin
                cls_c = CLASS_BRANCH; fmt_c = IMM_B;
                bad_c = (funct3_c == 3'd2) || (funct3_c == 3'd3);
            end
            OPC_LOAD: begin
                cls_c = CLASS_LOAD;  fmt_c = IMM_I; writes_c = 1'b1;
                bad_c = (funct3_c == 3'd7);
            end
            OPC_STORE: begin
                cls_c = CLASS_STORE; fmt_c = IMM_S;
                bad_c = funct3_c[2];
            end
            OPC_OP_IMM: begin
                cls_c = CLASS_OP_IMM; fmt_c = IMM_I; writes_c = 1'b1;
                // RV64 shifts carry a 6-bit shamt; only [31:26] qualifies them
                if (funct3_c == 3'd1)
                    bad_c = (shtype_c != 6'h00);
                else if (funct3_c == 3'd5)
                    bad_c = (shtype_c != 6'h00) && (shtype_c != 6'h10);
            end
            OPC_OP_IMM32: begin
                cls_c = CLASS_OP_IMM32; fmt_c = IMM_I; writes_c = 1'b1;
                case (funct3_c)
                    3'd0:    bad_c = 1'b0;
                    3'd1:    bad_c = (funct7_c != 7'h00);
                    3'd5:    bad_c = (funct7_c != 7'h00) && (funct7_c != 7'h20);
                    default: bad_c = 1'b1;
                endcase
            end
            OPC_OP: begin
                cls_c = CLASS_OP; writes_c = 1'b1;
                bad_c = !((funct7_c == 7'h00) ||
                          ((funct7_c == 7'h20) && ((funct3_c == 3'd0) || (funct3_c == 3'd5))));
            end
            OPC_OP32: begin
                cls_c = CLASS_OP32; writes_c = 1'b1;
                case (funct3_c)
                    3'd0, 3'd5: bad_c = (funct7_c != 7'h00) && (funct7_c != 7'h20);
                    3'd1:       bad_c = (funct7_c != 7'h00);
                    default:    bad_c = 1'b1;
                endcase
            end
            OPC_FENCE: begin
                cls_c = CLASS_FENCE;
            end
            OPC_SYSTEM: begin
                // CSR accesses (funct3 != 0) write rd; ECALL/EBREAK etc. do not
                cls_c = CLASS_SYSTEM; fmt_c = IMM_I;
                writes_c = (funct3_c != 3'd0);
            end
            default: begin
                bad_c = 1'b1;
            end
        endcase
        if (bad_c) begin
            cls_c = CLASS_ILLEGAL;
            fmt_c = IMM_NONE;
        end
    end

    assign rd_c = ((opcode_c == OPC_STORE) || (opcode_c == OPC_BRANCH)) ?
                  REG_W'(0) : instruction[11:7];

    always_comb begin
        dec_c         = '0;
        dec_c.cls     = cls_c;
        dec_c.rd      = rd_c;
        dec_c.rs1     = instruction[19:15];
        dec_c.rs2     = instruction[24:20];
        dec_c.funct3  = funct3_c;
        dec_c.funct7  = funct7_c;
        dec_c.rd_we   = writes_c && !bad_c && (rd_c != REG_W'(0));
        dec_c.illegal = bad_c;
    end

    idecode_imm #(
        .XLEN        (XLEN)
    ) u_imm (
        .instruction (instruction),
        .fmt         (fmt_c),
        .imm_c       (imm_c)
    );

    assign accept_c = instr_valid && armed && !flush && !stall;
    assign id_valid = (state == ST_FULL);

    // Slot FSM: flush beats stall beats accept; an unstalled slot is consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            armed      <= 1'b1;
            id_pc      <= '0;
            id_instr   <= '0;
            id_class   <= id_class_t'(4'd0);
            id_rd      <= '0;
            id_rs1     <= '0;
            id_rs2     <= '0;
            id_funct3  <= '0;
            id_funct7  <= '0;
            id_imm     <= '0;
            id_rd_we   <= 1'b0;
            id_illegal <= 1'b0;
`ifdef IDECODE_STATS_EN
            stat_decoded <= '0;
            stat_illegal <= '0;
`endif
        end else begin
            // A word in flight during a flush must never be captured later
            if (!instr_valid)
                armed <= 1'b1;
            else if (flush || accept_c)
                armed <= 1'b0;

            if (flush) begin
                state <= ST_EMPTY;
            end else if (stall) begin
                state <= state;
            end else if (accept_c) begin
                state      <= ST_FULL;
                id_pc      <= pc_current;
                id_instr   <= instruction;
                id_class   <= dec_c.cls;
                id_rd      <= dec_c.rd;
                id_rs1     <= dec_c.rs1;
                id_rs2     <= dec_c.rs2;
                id_funct3  <= dec_c.funct3;
                id_funct7  <= dec_c.funct7;
                id_imm     <= imm_c;
                id_rd_we   <= dec_c.rd_we;
                id_illegal <= dec_c.illegal;
`ifdef IDECODE_STATS_EN
                stat_decoded <= stat_decoded + 64'd1;
                if (dec_c.illegal)
                    stat_illegal <= stat_illegal + 64'd1;
`endif
            end else begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: a vector table of hand-decoded
// instructions fed through a scoreboard queue, plus stall, duplicate,
// flush and asynchronous-reset sequences.
module tb_idecode;
    import riscv_pkg::*;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            instr_valid;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc_current;
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    id_class_t       id_class;
    logic [4:0]      id_rd, id_rs1, id_rs2;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic [XLEN-1:0] id_imm;
    logic            id_rd_we;
    logic            id_illegal;
`ifdef IDECODE_STATS_EN
    logic [63:0]     stat_decoded, stat_illegal;
`endif

    idecode #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .pc_current   (pc_current),
        .stall        (stall),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_class     (id_class),
        .id_rd        (id_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_funct3    (id_funct3),
        .id_funct7    (id_funct7),
        .id_imm       (id_imm),
        .id_rd_we     (id_rd_we),
        .id_illegal   (id_illegal)
`ifdef IDECODE_STATS_EN
        ,
        .stat_decoded (stat_decoded),
        .stat_illegal (stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        id_class_t   cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        we;
        logic        ill;
        logic        full;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [63:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur;
    logic have_cur = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   emitted = 0;
    logic [63:0] exp_dec = 64'd0;
    logic [63:0] exp_ill = 64'd0;

    function automatic vec_t mk(input logic [31:0] ins, input id_class_t c,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [63:0] imm,
                                input logic we);
        vec_t v;
        v.instr = ins; v.cls = c; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.we = we; v.ill = 1'b0; v.full = 1'b1;
        return v;
    endfunction

    function automatic vec_t mkill(input logic [31:0] ins);
        vec_t v;
        v.instr = ins; v.cls = CLASS_ILLEGAL; v.rd = '0; v.rs1 = '0; v.rs2 = '0;
        v.f3 = '0; v.f7 = '0; v.imm = '0; v.we = 1'b0; v.ill = 1'b1; v.full = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("pc",      id_pc,              e.pc);
        chk("instr",   64'(id_instr),      64'(e.v.instr));
        chk("class",   64'(id_class),      64'(e.v.cls));
        chk("rd_we",   64'(id_rd_we),      64'(e.v.we));
        chk("illegal", 64'(id_illegal),    64'(e.v.ill));
        if (e.v.full) begin
            chk("rd",     64'(id_rd),     64'(e.v.rd));
            chk("rs1",    64'(id_rs1),    64'(e.v.rs1));
            chk("rs2",    64'(id_rs2),    64'(e.v.rs2));
            chk("funct3", 64'(id_funct3), 64'(e.v.f3));
            chk("funct7", 64'(id_funct7), 64'(e.v.f7));
            chk("imm",    id_imm,         e.v.imm);
        end
    endtask

    task automatic push(input vec_t v, input logic [63:0] pc);
        exp_t e;
        e.v = v; e.pc = pc;
        sb.push_back(e);
        exp_dec = exp_dec + 64'd1;
        if (v.ill) exp_ill = exp_ill + 64'd1;
    endtask

    // New output appears on any unstalled edge with id_valid; stalled edges must hold
    task automatic sample(input logic st);
        if (id_valid && !st) begin
            emitted++;
            if (sb.size() == 0) begin
                chk("unexpected_emit", 64'(id_instr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                cur = sb.pop_front();
                have_cur = 1'b1;
                compare(cur);
            end
        end else if (id_valid && st && have_cur) begin
            compare(cur);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic st, input logic fl);
        @(negedge clk);
        instr_valid = v; instruction = ins; pc_current = pc; stall = st; flush = fl;
        @(posedge clk);
        #1;
        sample(st);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},   64'(id_valid),   64'd0);
        chk({tag, "_pc"},      id_pc,           64'd0);
        chk({tag, "_instr"},   64'(id_instr),   64'd0);
        chk({tag, "_class"},   64'(id_class),   64'd0);
        chk({tag, "_rd"},      64'(id_rd),      64'd0);
        chk({tag, "_rs1"},     64'(id_rs1),     64'd0);
        chk({tag, "_imm"},     id_imm,          64'd0);
        chk({tag, "_rd_we"},   64'(id_rd_we),   64'd0);
        chk({tag, "_illegal"}, 64'(id_illegal), 64'd0);
`ifdef IDECODE_STATS_EN
        chk({tag, "_stat_dec"}, stat_decoded, 64'd0);
        chk({tag, "_stat_ill"}, stat_illegal, 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        vec_t va, vb;

        vecs.push_back(mk(32'h00500093, CLASS_OP_IMM,   5'd1,  5'd0, 5'd5,  3'd0, 7'h00, 64'd5, 1'b1));
        vecs.push_back(mk(32'hFE000EE3, CLASS_BRANCH,   5'd0,  5'd0, 5'd0,  3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0));
        vecs.push_back(mk(32'h800000B7, CLASS_LUI,      5'd1,  5'd0, 5'd0,  3'd0, 7'h40, 64'hFFFF_FFFF_8000_0000, 1'b1));
        vecs.push_back(mk(32'hFE21AC23, CLASS_STORE,    5'd0,  5'd3, 5'd2,  3'd2, 7'h7F, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0));
        vecs.push_back(mk(32'h001000EF, CLASS_JAL,      5'd1,  5'd0, 5'd1,  3'd0, 7'h00, 64'h800, 1'b1));
        vecs.push_back(mk(32'h00008067, CLASS_JALR,     5'd0,  5'd1, 5'd0,  3'd0, 7'h00, 64'd0, 1'b0));
        vecs.push_back(mk(32'h402081B3, CLASS_OP,       5'd3,  5'd1, 5'd2,  3'd0, 7'h20, 64'd0, 1'b1));
        vecs.push_back(mk(32'h40335293, CLASS_OP_IMM,   5'd5,  5'd6, 5'd3,  3'd5, 7'h20, 64'h403, 1'b1));
        vecs.push_back(mk(32'hFFF3839B, CLASS_OP_IMM32, 5'd7,  5'd7, 5'd31, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
        vecs.push_back(mk(32'h01013403, CLASS_LOAD,     5'd8,  5'd2, 5'd16, 3'd3, 7'h00, 64'd16, 1'b1));
        vecs.push_back(mk(32'h00001517, CLASS_AUIPC,    5'd10, 5'd0, 5'd0,  3'd1, 7'h00, 64'h1000, 1'b1));
        vecs.push_back(mk(32'h0FF0000F, CLASS_FENCE,    5'd0,  5'd0, 5'd31, 3'd0, 7'h07, 64'd0, 1'b0));
        vecs.push_back(mk(32'h403100BB, CLASS_OP32,     5'd1,  5'd2, 5'd3,  3'd0, 7'h20, 64'd0, 1'b1));
        vecs.push_back(mk(32'h00000013, CLASS_OP_IMM,   5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 64'd0, 1'b0));
        vecs.push_back(mk(32'h7FF00113, CLASS_OP_IMM,   5'd2,  5'd0, 5'd31, 3'd0, 7'h3F, 64'h7FF, 1'b1));
        vecs.push_back(mkill(32'h00000000));
        vecs.push_back(mkill(32'h00000001));
        vecs.push_back(mkill(32'h0000007F));
        vecs.push_back(mkill(32'h00009067));
        vecs.push_back(mkill(32'h00002063));
        vecs.push_back(mkill(32'h00007003));
        vecs.push_back(mkill(32'h00004023));
        vecs.push_back(mkill(32'h022081B3));
        vecs.push_back(mkill(32'h402091B3));
        vecs.push_back(mkill(32'h40009093));
        vecs.push_back(mkill(32'h0000203B));

        reset = 1'b1; instr_valid = 1'b0; instruction = '0; pc_current = '0;
        stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Table: one-cycle pulse, result one cycle later, then a bubble
        foreach (vecs[i]) begin
            push(vecs[i], 64'h100 + 64'(i) * 64'd4);
            cycle(1'b1, vecs[i].instr, 64'h100 + 64'(i) * 64'd4, 1'b0, 1'b0);
            chk("latency_valid", 64'(id_valid), 64'd1);
            cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
            chk("bubble_valid", 64'(id_valid), 64'd0);
        end

        // Same word held three cycles: exactly one capture
        e0 = emitted;
        va = vecs[0];
        push(va, 64'h2000);
        cycle(1'b1, va.instr, 64'h2000, 1'b0, 1'b0);
        cycle(1'b1, va.instr, 64'h2000, 1'b0, 1'b0);
        chk("dup_valid_drop", 64'(id_valid), 64'd0);
        cycle(1'b1, va.instr, 64'h2000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        chk("dup_count", 64'(emitted - e0), 64'd1);

        // Stall holds slot for 4 cycles while a new word waits
        va = vecs[6];
        vb = vecs[9];
        push(va, 64'h3000);
        cycle(1'b1, va.instr, 64'h3000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, vb.instr, 64'h3004, 1'b1, 1'b0);
            chk("stall_hold_valid", 64'(id_valid), 64'd1);
        end
        push(vb, 64'h3004);
        cycle(1'b1, vb.instr, 64'h3004, 1'b0, 1'b0);
        chk("post_stall_valid", 64'(id_valid), 64'd1);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Stall in EMPTY blocks capture until released
        va = vecs[2];
        cycle(1'b1, va.instr, 64'h3800, 1'b1, 1'b0);
        chk("empty_stall_valid", 64'(id_valid), 64'd0);
        push(va, 64'h3800);
        cycle(1'b1, va.instr, 64'h3800, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Flush while FULL with a word in flight: that word is never emitted
        va = vecs[4];
        vb = vecs[1];
        push(va, 64'h4000);
        cycle(1'b1, va.instr, 64'h4000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cycle(1'b1, vb.instr, 64'h4004, 1'b0, 1'b1);
        chk("flush_valid", 64'(id_valid), 64'd0);
        cycle(1'b1, vb.instr, 64'h4004, 1'b0, 1'b0);
        chk("flushed_not_captured", 64'(id_valid), 64'd0);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        va = vecs[7];
        push(va, 64'h4008);
        cycle(1'b1, va.instr, 64'h4008, 1'b0, 1'b0);
        chk("after_flush_valid", 64'(id_valid), 64'd1);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Illegal word held FULL, then asynchronous reset mid-cycle
        va = vecs[15];
        push(va, 64'h5000);
        cycle(1'b1, va.instr, 64'h5000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("illegal_full_valid", 64'(id_valid), 64'd1);
`ifdef IDECODE_STATS_EN
        chk("stat_decoded", stat_decoded, exp_dec);
        chk("stat_illegal", stat_illegal, exp_ill);
`endif
        chk("sb_drain", 64'(sb.size()), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        have_cur = 1'b0;
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;

        va = vecs[10];
        push(va, 64'h6000);
        cycle(1'b1, va.instr, 64'h6000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
`ifdef IDECODE_STATS_EN
        chk("stat_after_reset", stat_decoded, 64'd1);
`endif
        chk("sb_final", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idecode.md
Name: idecode

Overview:
- Instruction decode stage for the RV64I pipeline, directly downstream of instruction fetch.
- Accepts one fetched instruction and its PC from fetch.
- Decodes register indices, funct fields, instruction class and a sign-extended immediate.
- Presents the result to execute from a single registered pipeline slot, with stall-hold, flush and duplicate-capture suppression.

Parameters:
- XLEN, 9'd64, datapath/PC width; immediates are sign-extended to XLEN.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  fetch has a valid instruction (may stay high for several cycles for the same instruction).
- instruction  in  32  fetched instruction word.
- pc_current  in  XLEN  PC of instruction.
- stall  in  1  downstream cannot accept; hold output slot.
- flush  in  1  kill slot contents (redirect/trap).
- id_valid  out  1  output slot holds a decoded instruction.
- id_pc  out  XLEN  PC of decoded instruction.
- id_instr  out  32  raw instruction word.
- id_class  out  4  instruction class (enum from package).
- id_rd, id_rs1, id_rs2  out  5 each  register indices.
- id_funct3  out  3  funct3 field.
- id_funct7  out  7  funct7 field.
- id_imm  out  XLEN  sign-extended immediate.
- id_rd_we  out  1  instruction writes rd, with rd!=0.
- id_illegal  out  1  illegal/unsupported encoding.

Behaviour:
- Reset: every output and all internal state go to 0; state=EMPTY; armed=1.
- Duplicate suppression (armed flag):
  - A capture clears armed.
  - armed is set again on any cycle with instr_valid=0.
  - An instruction is accepted only when instr_valid && armed.
- States:
  - EMPTY: id_valid=0.
  - FULL: id_valid=1, outputs stable.
- Priority each cycle is flush > stall > accept:
  - flush: next state=EMPTY, id_valid=0. Nothing is captured that cycle, even if instr_valid is high. armed is cleared when instr_valid=1, so the flushed-in-flight instruction is never captured.
  - stall (no flush): state and all outputs held unchanged. No capture, even in EMPTY.
  - accept (no flush, no stall, instr_valid, armed): decode into the slot, state=FULL, armed=0.
  - otherwise: state=EMPTY (the slot is consumed by execute whenever stall=0).
- Latency: one cycle from an accepted instr_valid edge to id_valid=1. Back-to-back throughput is one instruction per cycle when armed allows.
- Decode, combinational from instruction, registered on capture:
  - opcode[1:0]!=2'b11 gives illegal.
  - Classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_IMM32, OP, OP32, FENCE, SYSTEM, ILLEGAL.
- Immediates, all sign-extended from instruction[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}, sign-extended to XLEN
  - J: {[31],[19:12],[20],[30:21],0}
  - R-type and FENCE: 0.
- id_rd forced to 0 for STORE and BRANCH. id_rd_we=1 only for classes writing rd with rd!=0, and never when illegal.
- Illegal when any of:
  - unknown opcode
  - JALR funct3!=0
  - BRANCH funct3 in {2,3}
  - LOAD funct3=7
  - STORE funct3>3
  - OP funct7 not in {0x00,0x20}, or 0x20 with funct3 not in {0,5}
  - OP_IMM shifts with [31:26] not in {0x00,0x10}, or 0x10 with funct3=1
  - OP_IMM32/OP32 unsupported funct3/funct7 combos
- Illegal instructions still occupy the slot with id_valid=1, id_illegal=1, class=ILLEGAL.
- Reset asserted mid-operation: immediate asynchronous clear, with no partial outputs.

Optional Feature:
- Macro: IDECODE_STATS_EN.
- Defined: adds outputs stat_decoded (64) and stat_illegal (64).
  - Each is incremented on every accept, and illegal counts only accepts with illegal=1.
  - Both wrap modulo 2^64 and are cleared by reset.
  - A flush does not decrement them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package riscv_pkg holds:
  - the opcode localparams (7-bit),
  - the id_class_t enum (4-bit) with the values listed above,
  - the immediate-format enum.
- Sub-module idecode_imm: purely combinational immediate generator (instruction, format → XLEN imm). All state stays in idecode.

Test Plan:
- addi x1,x0,5 (0x00500093), pc=0x100, instr_valid pulse → next cycle id_valid=1, class=OP_IMM, rd=1, rs1=0, imm=5, rd_we=1, id_pc=0x100.
- beq x0,x0,-4 (0xFE000EE3) → class=BRANCH, imm=0xFFFFFFFFFFFFFFFC, rd=0, rd_we=0.
- instr_valid held high 3 cycles with the same word → exactly one capture; id_valid high 1 cycle (stall=0); stats +1 if enabled.
- Captured instruction, then stall=1 for 4 cycles while new instr_valid arrives → outputs unchanged throughout; new word captured the cycle after stall drops (if still valid and armed).
- flush asserted with instr_valid=1 and the slot FULL → id_valid=0 next cycle; that instruction is never emitted; next fresh instr_valid decodes normally.
- 0x00000000 → id_valid=1, id_illegal=1, class=ILLEGAL, rd_we=0; reset asserted mid-FULL → all outputs 0 asynchronously.
